crc_frame_seq: RTL and testbench

- Frame sequencer for the team's bit-serial CRC engine.
- Accepts a byte stream with valid/ready/last and serializes each byte into the engine, one bit per clock.
- Resets the engine at the start of each frame and captures the final CRC with a one-cycle done pulse.
- Sits between a byte-wide packet datapath and one external CRC engine instance. The engine's clock is shared; its reset, data and enable inputs are driven only by this block.

---
 rtl/crc_frame_seq.sv | 141 ++++++++++++++
 tb/tb_crc_frame_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_seq.sv
// rtl/crc_frame_seq.sv - byte-stream frame sequencer driving a bit-serial CRC engine
// Optional compare against an expected CRC: define CRC_FRAME_SEQ_CHECK_EN.
module crc_frame_seq #(
    parameter int BITS   = 8,
    parameter int DW     = 8,
    parameter int REF_IN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    input  logic            abort,
    output logic            crc_rst,
    output logic            crc_bit,
    output logic            crc_en,
    input  logic [BITS-1:0] crc_val,
    output logic [BITS-1:0] crc_result,
    output logic            done,
    output logic            busy
`ifdef CRC_FRAME_SEQ_CHECK_EN
    ,
    input  logic [BITS-1:0] exp_crc,
    output logic            crc_ok
`endif
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            sof_flag;
    logic            last_q;
    logic [DW-1:0]   shreg;
    logic [CW-1:0]   cnt;
    logic            accept;

`ifdef CRC_FRAME_SEQ_CHECK_EN
    logic [BITS-1:0] exp_crc_q;
`endif

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        crc_en    = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = ~abort;
                accept   = in_valid & ~abort;
                if (accept) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                crc_en = ~abort;
                if (cnt == CNT_LAST) begin
                    state_nxt = last_q ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
        if (rst) begin
            in_ready  = 1'b0;
            crc_en    = 1'b0;
            accept    = 1'b0;
            state_nxt = S_IDLE;
        end
    end

    // Engine loads INIT on the edge that accepts the first word of a frame.
    assign crc_rst = rst | (accept & sof_flag);
    assign crc_bit = (REF_IN != 0) ? shreg[0] : shreg[DW-1];
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            sof_flag   <= 1'b1;
            last_q     <= 1'b0;
            shreg      <= '0;
            cnt        <= '0;
            crc_result <= '0;
            done       <= 1'b0;
`ifdef CRC_FRAME_SEQ_CHECK_EN
            exp_crc_q  <= '0;
            crc_ok     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (accept) begin
                shreg    <= in_data;
                last_q   <= in_last;
                cnt      <= '0;
                sof_flag <= 1'b0;
`ifdef CRC_FRAME_SEQ_CHECK_EN
                if (in_last) begin
                    exp_crc_q <= exp_crc;
                end
`endif
            end else if (state == S_SHIFT && !abort) begin
                if (REF_IN != 0) begin
                    shreg <= {1'b0, shreg[DW-1:1]};
                end else begin
                    shreg <= {shreg[DW-2:0], 1'b0};
                end
                cnt <= cnt + 1'b1;
            end
            // The engine has consumed every bit by the DONE cycle.
            if (state == S_DONE && !abort) begin
                crc_result <= crc_val;
                done       <= 1'b1;
                sof_flag   <= 1'b1;
`ifdef CRC_FRAME_SEQ_CHECK_EN
                crc_ok     <= (crc_val == exp_crc_q);
`endif
            end
            if (abort) begin
                sof_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crc_frame_seq.sv
// tb/tb_crc_frame_seq.sv - directed bench for crc_frame_seq with a CRC-8/WCDMA engine stand-in
module tb_crc_frame_seq;

    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       abort = 1'b0;
    logic       crc_rst, crc_bit, crc_en;
    logic [7:0] crc_val;
    logic [7:0] crc_result;
    logic       done, busy;
    logic [7:0] exp_crc = 8'h00;
`ifdef CRC_FRAME_SEQ_CHECK_EN
    logic       crc_ok;
`endif

    crc_frame_seq #(.BITS(8), .DW(DW), .REF_IN(1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .abort(abort),
        .crc_rst(crc_rst), .crc_bit(crc_bit), .crc_en(crc_en),
        .crc_val(crc_val), .crc_result(crc_result), .done(done), .busy(busy)
`ifdef CRC_FRAME_SEQ_CHECK_EN
        , .exp_crc(exp_crc), .crc_ok(crc_ok)
`endif
    );

    always #5 clk = ~clk;

    // Engine stand-in: CRC-8 poly 0x9B, INIT 0, output reflected, no final XOR.
    logic [7:0] eng;
    always @(posedge clk) begin
        if (crc_rst) eng <= 8'h00;
        else if (crc_en) eng <= {eng[6:0], 1'b0} ^ ((eng[7] ^ crc_bit) ? 8'h9B : 8'h00);
    end
    always_comb begin
        for (int i = 0; i < 8; i++) crc_val[i] = eng[7-i];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [7:0] msg [0:8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 8'hD9) : (r >> 1);
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

    // Reference model: word timing from accept-cycle arithmetic, CRC byte-wise.
    int         mc = 0;
    int         acc_c = 0;
    bit         active = 0, sof = 1, primed = 0, acc_last = 0, m_done = 0;
    logic [7:0] acc_d = 8'h00, run_crc = 8'h00, m_result = 8'h00;
    bit         m_ok = 0;
    logic [7:0] m_expq = 8'h00;

    always @(negedge clk) begin
        int k;
        bit e_ready, e_en, e_crst, e_busy, nd;
        k = mc - acc_c;
        e_busy = active;
        if (rst) begin
            e_ready = 0; e_en = 0; e_crst = 1;
        end else if (active) begin
            e_ready = 0; e_en = (k <= DW) && !abort; e_crst = 0;
        end else begin
            e_ready = !abort; e_en = 0; e_crst = in_valid && !abort && sof;
        end
        if (primed) begin
            check("in_ready", in_ready, e_ready);
            check("crc_en", crc_en, e_en);
            check("crc_rst", crc_rst, e_crst);
            check("busy", busy, e_busy);
            check("done", done, m_done);
            check("crc_result", crc_result, m_result);
            if (e_en) check("crc_bit", crc_bit, acc_d[k-1]);
`ifdef CRC_FRAME_SEQ_CHECK_EN
            check("crc_ok", crc_ok, m_ok);
`endif
        end
        nd = 0;
        if (rst) begin
            active = 0; sof = 1; m_result = 8'h00; m_ok = 0; primed = 1;
        end else if (abort) begin
            active = 0; sof = 1;
        end else if (active) begin
            if (k == DW && !acc_last) active = 0;
            else if (k == DW + 1) begin
                active = 0; sof = 1; m_result = run_crc; m_ok = (run_crc == m_expq); nd = 1;
            end
        end else if (in_valid) begin
            if (sof) run_crc = 8'h00;
            run_crc = crc_byte(run_crc, in_data);
            acc_d = in_data; acc_last = in_last; acc_c = mc; active = 1; sof = 0;
            if (in_last) m_expq = exp_crc;
        end
        m_done = nd;
        mc++;
    end

    task automatic send_byte(input logic [7:0] b, input logic last, output logic rst_seen, output int acc_at);
        bit got;
        got = 0; rst_seen = 0; acc_at = 0;
        in_data = b; in_last = last; in_valid = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got = 1; rst_seen = crc_rst; acc_at = cyc;
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: byte %h not accepted within 50 cycles", b);
        end
    endtask

    task automatic send_msg(input int n, input bit mark_last, output logic first_rst,
                            output int first_acc, output int last_acc);
        logic r;
        int a;
        first_rst = 0; first_acc = 0; last_acc = 0;
        for (int i = 0; i < n; i++) begin
            send_byte(msg[i], mark_last && (i == n - 1), r, a);
            if (i == 0) begin first_rst = r; first_acc = a; end
            last_acc = a;
        end
    endtask

    task automatic wait_done(output int at);
        bit got;
        got = 0; at = 0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin got = 1; at = cyc; end
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: no done pulse within 40 cycles");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic r;
        int fa, la, dc, d0, en_cnt, ones;
        logic [7:0] pin;
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
        pin = 8'h00;
        for (int i = 0; i < 9; i++) pin = crc_byte(pin, msg[i]);
        check("model_pin_check_value", pin, 8'h25);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_crc_result", crc_result, 8'h00);
        check("rst_done", done, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_crc_en", crc_en, 1'b0);
        check("rst_crc_rst", crc_rst, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Full check string with valid held through the frame
        send_msg(9, 1, r, fa, la);
        in_valid = 1'b0;
        wait_done(dc);
        check("t1_first_crc_rst", r, 1'b1);
        check("t1_word_spacing", la - fa, 72);
        check("t1_done_latency", dc - fa, 82);
        check("t1_crc_result", crc_result, 8'h25);

        // Single zero byte frame
        send_byte(8'h00, 1'b1, r, fa);
        in_valid = 1'b0;
        en_cnt = 0; ones = 0;
        for (int i = 1; i <= DW + 2; i++) begin
            @(negedge clk);
            if (i <= DW + 1) begin
                en_cnt += int'(crc_en);
                if (crc_en) ones += int'(crc_bit);
            end
            if (i == DW + 1) check("t2_no_early_done", done, 1'b0);
            if (i == DW + 2) check("t2_done_at_10", done, 1'b1);
        end
        @(posedge clk); #1;
        check("t2_crc_rst", r, 1'b1);
        check("t2_en_cycles", en_cnt, 8);
        check("t2_bits_zero", ones, 0);
        check("t2_crc_result", crc_result, 8'h00);

        // Abort mid-shift of the second byte, then a clean frame
        d0 = done_cnt;
        send_byte(8'h31, 1'b0, r, fa);
        send_byte(8'h32, 1'b0, r, fa);
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (12) @(posedge clk); #1;
        check("t3_no_done_on_abort", done_cnt - d0, 0);
        check("t3_result_held", crc_result, 8'h00);
        send_msg(9, 1, r, fa, la);
        in_valid = 1'b0;
        wait_done(dc);
        check("t3_crc_rst_after_abort", r, 1'b1);
        check("t3_crc_result", crc_result, 8'h25);

        // Reset during shift
        send_byte(8'h31, 1'b0, r, fa);
        send_byte(8'h32, 1'b0, r, fa);
        in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t4_busy", busy, 1'b0);
        check("t4_crc_result", crc_result, 8'h00);
        check("t4_done", done, 1'b0);
        check("t4_crc_en", crc_en, 1'b0);
        @(posedge clk); #1;
        send_msg(9, 1, r, fa, la);
        in_valid = 1'b0;
        wait_done(dc);
        check("t4_crc_result_after", crc_result, 8'h25);

        // Back-to-back frames with valid never dropped
        d0 = done_cnt;
        send_msg(9, 1, r, fa, la);
        send_msg(9, 1, r, fa, dc);
        in_valid = 1'b0;
        check("t5_second_crc_rst", r, 1'b1);
        check("t5_frame_gap", fa - la, DW + 2);
        wait_done(dc);
        check("t5_two_dones", done_cnt - d0, 2);
        check("t5_crc_result", crc_result, 8'h25);

`ifdef CRC_FRAME_SEQ_CHECK_EN
        exp_crc = 8'h25;
        send_msg(9, 1, r, fa, la);
        in_valid = 1'b0;
        exp_crc = 8'h00;
        wait_done(dc);
        check("t6_crc_ok_match", crc_ok, 1'b1);
        exp_crc = 8'h24;
        send_msg(9, 1, r, fa, la);
        in_valid = 1'b0;
        exp_crc = 8'h25;
        wait_done(dc);
        check("t6_crc_ok_mismatch", crc_ok, 1'b0);
`endif

        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
